i2s_transmitter: RTL
====================

# i2s_transmitter

Serializes processed stereo samples from the effect chain (distortion output and later stages) onto an I2S link to the codec DAC. Accepts one left/right 24-bit two's-complement sample pair per frame through a valid/ready handshake. Generates BCLK and LRCLK from the system clock and shifts data MSB-first in standard I2S format, with a one-BCLK delay after each LRCLK edge. It is the transmit-side counterpart of the codec receive path that feeds the effect modules.

## Interface
- `WIDTH`, 24: sample width in bits; must satisfy WIDTH <= SLOT_BITS-1.
- `SLOT_BITS`, 32: BCLK periods per channel slot.
- `BCLK_DIV`, 4: clk cycles per BCLK half-period; must be >= 2.
- `clk` in 1: system clock; one clock domain.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: link enable.
- `left_in` in WIDTH: left sample, signed.
- `right_in` in WIDTH: right sample, signed.
- `in_valid` in 1: sample pair valid.
- `in_ready` out 1: staging register empty. Combinational: `enable & ~reset & ~staging_full`.
- `bclk` out 1: bit clock, registered.
- `lrclk` out 1: word select, registered; 0 = left, 1 = right.
- `sdata` out 1: serial data, registered; changes only on BCLK falling edges.
- `underrun` out 1: one-clk pulse when a frame starts with the staging register empty.

## Operation
- **Reset.** Clears `bclk`, `lrclk`, `sdata` and `underrun` to 0. Empties the staging register. Zeroes the active shift registers. Sets `div_cnt` to 0 and `bit_cnt` to 2*SLOT_BITS-1.
- **Accept.** A pair is accepted when `in_valid & in_ready` at a clk edge; it is stored in the staging register and `staging_full` is set.
- **BCLK divider.** `div_cnt` counts 0..BCLK_DIV-1. At terminal count, `bclk` toggles and `div_cnt` wraps. A 1->0 toggle is a *shift tick*.
- **Bit counter.** On each shift tick, `bit_cnt` increments modulo 2*SLOT_BITS. Slot index s = bit_cnt mod SLOT_BITS.
- **Word select.** `lrclk` is 0 for bit_cnt < SLOT_BITS and 1 otherwise; it is updated on the same shift tick as `bit_cnt`.
- **Serial data.** For s in 1..WIDTH, `sdata` = channel bit WIDTH-s (MSB at s=1). At s=0 and for s > WIDTH, `sdata` = 0.
- **Frame start (shift tick where bit_cnt becomes 0).**
  - If staging is full: staging moves to the active left/right registers and `staging_full` clears.
  - If staging is empty: active registers are loaded with zeros and `underrun` pulses for 1 clk.
  - An accept on the same edge as a frame start that found staging empty does not rescue that frame. The pair is stored and is sent on the next frame.
- **Enable.**
  - `enable` low: divider and bit counter are held at their reset values, `bclk`, `lrclk` and `sdata` are driven 0, and `in_ready` is 0.
  - Staging contents are retained while `enable` is low.
  - Re-enable behaves as reset release, except that staged data is kept.
- **Reset mid-frame.** The frame is abandoned, outputs return to 0 on the next edge, and staged data is discarded.

## Timing
- Reset release is cycle 0, with `enable`=1.
  - `bclk` first rises at the cycle-BCLK_DIV edge.
  - `bclk` first falls at the cycle-2*BCLK_DIV edge. This is the first frame start: lrclk=0, sdata=0.
  - Left MSB appears at the cycle-4*BCLK_DIV edge (16 with defaults).
- A pair must be accepted at an edge strictly before the frame-start edge to be sent in that frame. Latency from accept to MSB is at most one frame period plus 2*BCLK_DIV cycles.
- Frame period is 4*SLOT_BITS*BCLK_DIV clk cycles (512 with defaults). The design sustains at most one accepted pair per frame.
- `in_ready` rises on the clk edge after the frame-start load that empties staging.
- Right MSB appears 2*BCLK_DIV cycles after `lrclk` rises.

## Structure
- Package `i2s_pkg` holds:
  - the default constants WIDTH, SLOT_BITS and BCLK_DIV;
  - a `stereo_sample_t` struct with `left` and `right` fields, each logic [WIDTH-1:0];
  - a function returning the frame period in clk cycles.
- Sub-module `bclk_gen` contains the divider, the `bclk` register and the shift-tick/rise-tick strobes, with `clk`, `reset` and `enable` inputs. The top level holds staging, shift registers, `bit_cnt` and the output registers.

## Test plan
- **Single frame.** Defaults; left=24'h800001, right=24'h7FFFFE accepted before cycle 8.
  - Left slot: sdata bits 1..24 = 1000...0001, bits 25..31 = 0.
  - Right slot: 0111...1110.
  - `underrun` never pulses.
- **Underrun.** No input is offered.
  - `underrun` pulses at cycle 8 and then every 512 cycles.
  - sdata stays 0.
  - lrclk toggles every 256 cycles.
- **Back-pressure.** `in_valid` held high with an incrementing pair count.
  - `in_ready` is high for exactly 1 cycle per frame after each load.
  - Consecutive frames carry consecutive values with none skipped.
- **Late accept.** Accept on the frame-start edge with staging empty.
  - `underrun` pulses and that frame carries zeros.
  - The next frame carries the pair.
- **Enable toggle mid-right-slot.**
  - `bclk`, `lrclk` and `sdata` go to 0 on the next edge and `in_ready` goes to 0.
  - After re-enable, the staged pair appears in the first frame; the left MSB arrives 16 cycles after re-enable.
- **Reset mid-frame with staging full.**
  - Outputs are 0 on the next edge.
  - After release, the first frame underruns; staging was cleared.

Source files
------------

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants and types for the I2S transmit path.
//   WIDTH      default sample width in bits
//   SLOT_BITS  default BCLK periods per channel slot
//   BCLK_DIV   default clk cycles per BCLK half-period
//   stereo_sample_t  left/right sample pair
//   frame_period()   clk cycles per stereo frame
package i2s_pkg;

    localparam int unsigned WIDTH     = 24;
    localparam int unsigned SLOT_BITS = 32;
    localparam int unsigned BCLK_DIV  = 4;

    typedef struct packed {
        logic [WIDTH-1:0] left;
        logic [WIDTH-1:0] right;
    } stereo_sample_t;

    // Two slots per frame, two BCLK half-periods per bit.
    function automatic int unsigned frame_period(input int unsigned slot_bits,
                                                 input int unsigned bclk_div);
        return 4 * slot_bits * bclk_div;
    endfunction

endpackage

// File: rtl/i2s_transmitter_bclk_gen.sv
// bclk_gen: bit-clock divider for the I2S transmitter.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   enable     in   link enable; low holds the divider and bclk at reset values
//   bclk       out  registered bit clock
//   shift_tick out  high in the cycle whose edge takes bclk 1->0
//   rise_tick  out  high in the cycle whose edge takes bclk 0->1
module bclk_gen #(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic bclk,
    output logic shift_tick,
    output logic rise_tick
);

    import i2s_pkg::*;

    localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             bclk_q, bclk_d;
    logic             terminal;

    always_comb begin
        terminal  = enable && (div_cnt_q == DIV_LAST);
        div_cnt_d = div_cnt_q + DIV_W'(1);
        bclk_d    = bclk_q;
        if (!enable) begin
            div_cnt_d = '0;
            bclk_d    = 1'b0;
        end else if (terminal) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
        end
    end

    // Strobes are qualified by reset so the top never advances on a reset edge.
    assign shift_tick = ~reset & terminal & bclk_q;
    assign rise_tick  = ~reset & terminal & ~bclk_q;
    assign bclk       = bclk_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

endmodule

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: serializes stereo sample pairs onto a standard I2S link
// (MSB first, one BCLK delay after each LRCLK edge).
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   enable    in   link enable
//   left_in   in   left sample (two's complement)
//   right_in  in   right sample (two's complement)
//   in_valid  in   sample pair valid
//   in_ready  out  staging register empty (combinational)
//   bclk      out  bit clock
//   lrclk     out  word select, 0 = left, 1 = right
//   sdata     out  serial data, changes on bclk falling edges
//   underrun  out  one-cycle pulse when a frame starts with nothing staged
module i2s_transmitter #(
    parameter int unsigned WIDTH     = 24,
    parameter int unsigned SLOT_BITS = 32,
    parameter int unsigned BCLK_DIV  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] left_in,
    input  logic [WIDTH-1:0] right_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bclk,
    output logic             lrclk,
    output logic             sdata,
    output logic             underrun
);

    import i2s_pkg::*;

    localparam int unsigned CNT_W = $clog2(2 * SLOT_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_BITS - 1);
    localparam logic [CNT_W-1:0] SLOT_L   = CNT_W'(SLOT_BITS);
    localparam logic [CNT_W-1:0] WIDTH_L  = CNT_W'(WIDTH);

    logic shift_tick;
    logic rise_tick;

    bclk_gen #(
        .BCLK_DIV(BCLK_DIV)
    ) u_bclk_gen (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .bclk      (bclk),
        .shift_tick(shift_tick),
        .rise_tick (rise_tick)
    );

    logic [WIDTH-1:0] staging_left_q, staging_left_d;
    logic [WIDTH-1:0] staging_right_q, staging_right_d;
    logic             staging_full_q, staging_full_d;
    logic [WIDTH-1:0] active_left_q, active_left_d;
    logic [WIDTH-1:0] active_right_q, active_right_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             lrclk_q, lrclk_d;
    logic             sdata_q, sdata_d;
    logic             next_bit_q, next_bit_d;
    logic             underrun_q, underrun_d;

    logic [CNT_W-1:0] bit_cnt_inc;
    logic             accept;
    logic             frame_start;

    // Wire bit for frame position cnt: slot bits 1..WIDTH carry the sample MSB first.
    function automatic logic serial_bit(input logic [CNT_W-1:0] cnt,
                                        input logic [WIDTH-1:0] l,
                                        input logic [WIDTH-1:0] r);
        logic [CNT_W-1:0] s;
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] sh;
        if (cnt >= SLOT_L) begin
            s = cnt - SLOT_L;
            w = r;
        end else begin
            s = cnt;
            w = l;
        end
        sh = w >> (WIDTH_L - s);
        return (s != '0) && (s <= WIDTH_L) && sh[0];
    endfunction

    assign in_ready = enable & ~reset & ~staging_full_q;
    assign accept   = in_valid & in_ready;

    always_comb begin
        bit_cnt_inc = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + CNT_W'(1);
        frame_start = shift_tick && (bit_cnt_inc == '0);

        staging_left_d  = staging_left_q;
        staging_right_d = staging_right_q;
        staging_full_d  = staging_full_q;
        active_left_d   = active_left_q;
        active_right_d  = active_right_q;
        bit_cnt_d       = bit_cnt_q;
        lrclk_d         = lrclk_q;
        sdata_d         = sdata_q;
        next_bit_d      = next_bit_q;
        underrun_d      = 1'b0;

        if (!enable) begin
            // Link parked: behave as after reset but keep whatever is staged.
            bit_cnt_d      = CNT_LAST;
            lrclk_d        = 1'b0;
            sdata_d        = 1'b0;
            next_bit_d     = 1'b0;
            active_left_d  = '0;
            active_right_d = '0;
        end else begin
            if (accept) begin
                staging_left_d  = left_in;
                staging_right_d = right_in;
                staging_full_d  = 1'b1;
            end
            // The next wire bit is fetched mid-bit so the falling edge only has to
            // register it; the frame-start load always precedes the fetch of bit 1.
            if (rise_tick) begin
                next_bit_d = serial_bit(bit_cnt_inc, active_left_q, active_right_q);
            end
            if (shift_tick) begin
                bit_cnt_d = bit_cnt_inc;
                lrclk_d   = (bit_cnt_inc >= SLOT_L);
                sdata_d   = next_bit_q;
            end
            // accept and a full-staging load are exclusive (in_ready is low when full),
            // so a same-edge accept into empty staging survives for the next frame.
            if (frame_start) begin
                if (staging_full_q) begin
                    active_left_d  = staging_left_q;
                    active_right_d = staging_right_q;
                    staging_full_d = 1'b0;
                end else begin
                    active_left_d  = '0;
                    active_right_d = '0;
                    underrun_d     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            staging_left_q  <= '0;
            staging_right_q <= '0;
            staging_full_q  <= 1'b0;
            active_left_q   <= '0;
            active_right_q  <= '0;
            bit_cnt_q       <= CNT_LAST;
            lrclk_q         <= 1'b0;
            sdata_q         <= 1'b0;
            next_bit_q      <= 1'b0;
            underrun_q      <= 1'b0;
        end else begin
            staging_left_q  <= staging_left_d;
            staging_right_q <= staging_right_d;
            staging_full_q  <= staging_full_d;
            active_left_q   <= active_left_d;
            active_right_q  <= active_right_d;
            bit_cnt_q       <= bit_cnt_d;
            lrclk_q         <= lrclk_d;
            sdata_q         <= sdata_d;
            next_bit_q      <= next_bit_d;
            underrun_q      <= underrun_d;
        end
    end

    assign lrclk    = lrclk_q;
    assign sdata    = sdata_q;
    assign underrun = underrun_q;

endmodule
